// File: rtl/tinysat_pkg.sv
// tinysat_pkg
// Shared definitions for the tinysat brute-force SAT search block:
//   - state_e   : search controller states
//   - lw_of()   : width of a signed literal for a given variable count
//   - lit_eval(): truth of one signed literal against an assignment
// Literals are encoded as signed integers: +v selects x[v-1], -v selects
// ~x[v-1], and 0 marks an empty slot that never contributes truth.
package tinysat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EVAL      = 2'd1,
        ST_FOUND     = 2'd2,
        ST_EXHAUSTED = 2'd3
    } state_e;

    // Widest literal / assignment the evaluation function accepts. Callers
    // sign-extend literals and zero-extend assignments to these widths.
    localparam int LW_MAX = 8;
    localparam int NV_MAX = 16;

    // One sign bit on top of enough magnitude bits to hold NVARS.
    function automatic int lw_of(input int nvars);
        return $clog2(nvars + 1) + 1;
    endfunction

    // A literal whose magnitude exceeds the supported range is treated as
    // false rather than aliasing onto a low variable.
    function automatic logic lit_eval(input logic signed [LW_MAX-1:0] lit,
                                      input logic [NV_MAX-1:0] xv);
        logic [LW_MAX-1:0] mag;
        logic [3:0]        idx;
        logic              r;
        mag = lit[LW_MAX-1] ? LW_MAX'(-lit) : LW_MAX'(lit);
        idx = 4'(mag - 8'd1);
        if (lit == 8'sd0) begin
            r = 1'b0;
        end else if (mag > 8'd16) begin
            r = 1'b0;
        end else if (lit[LW_MAX-1]) begin
            r = ~xv[idx];
        end else begin
            r = xv[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/tinysat_clause_eval.sv
// tinysat_clause_eval
// Purely combinational truth of one clause: the OR of its K literals
// evaluated against the current assignment. An all-empty clause is false.
// Ports:
//   lits  in  K*LW  packed literals, slot 0 in the low LW bits
//   x     in  NVARS current assignment
//   truth out 1     clause value
module tinysat_clause_eval
    import tinysat_pkg::*;
#(
    parameter int NVARS = 6,
    parameter int K     = 3,
    parameter int LW    = lw_of(NVARS)
) (
    input  logic [K*LW-1:0]  lits,
    input  logic [NVARS-1:0] x,
    output logic             truth
);

    logic [NV_MAX-1:0] xw_s;
    logic              truth_s;

    assign xw_s = NV_MAX'(x);

    // OR together the individual literal values of this clause.
    always_comb begin
        truth_s = 1'b0;
        for (int j = 0; j < K; j++) begin
            truth_s = truth_s | lit_eval(LW_MAX'(signed'(lits[j*LW +: LW])), xw_s);
        end
    end

    assign truth = truth_s;

endmodule

// File: rtl/tinysat_param.sv
// tinysat_param
// Brute-force SAT search over NVARS variables. Literals are streamed into a
// clause-major memory while idle; run then walks every assignment from 0,
// testing one clause per cycle, and stops on the first satisfying one.
// next resumes the walk after a solution.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   load, data    append data as the next literal (idle only, until full)
//   clr           clear clause memory and counters, return to idle
//   run           start a fresh search from assignment 0
//   next          continue after a found solution
//   x             current assignment
//   sol/done/busy found / found-or-exhausted / evaluating
//   full          literal memory holds NCLAUSES*K literals
//   nsol          solutions found since the last run
module tinysat_param
    import tinysat_pkg::*;
#(
    parameter  int NVARS    = 6,
    parameter  int NCLAUSES = 8,
    parameter  int K        = 3,
    localparam int LW       = lw_of(NVARS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clr,
    input  logic             run,
    input  logic             next,
    input  logic [LW-1:0]    data,
    output logic [NVARS-1:0] x,
    output logic             sol,
    output logic             done,
    output logic             busy,
    output logic             full,
    output logic [NVARS:0]   nsol
);

    localparam int NSLOTS = NCLAUSES * K;
    localparam int CW     = $clog2(NSLOTS + 1);
    localparam int CIW    = $clog2(NCLAUSES + 1);
    localparam int KW     = $clog2(K + 1);
    localparam int NW     = NVARS + 1;

    logic [LW-1:0]    mem_r [NSLOTS];

    state_e           state_r, state_s;
    logic [NVARS-1:0] x_r, x_s;
    logic [CIW-1:0]   ci_r, ci_s;
    logic [NW-1:0]    nsol_r, nsol_s;
    logic [CW-1:0]    lcnt_r, lcnt_s;
    logic [KW-1:0]    kcnt_r, kcnt_s;   // slot position inside the clause being filled
    logic [CIW-1:0]   ncl_r, ncl_s;     // clauses touched so far = ceil(lcnt/K)
    logic             full_r, full_s;
    logic             sol_r, done_r, busy_r;
    logic             sol_s, done_s, busy_s;
    logic             load_ok_s;
    logic [K*LW-1:0]  clause_lits_s;
    logic             clause_true_s;

    // Gather the K literals of clause ci from the flat memory.
    always_comb begin
        clause_lits_s = '0;
        for (int c = 0; c < NCLAUSES; c++) begin
            if (ci_r == CIW'(c)) begin
                for (int j = 0; j < K; j++) begin
                    clause_lits_s[j*LW +: LW] = mem_r[c*K + j];
                end
            end else begin
                clause_lits_s = clause_lits_s;
            end
        end
    end

    tinysat_clause_eval #(
        .NVARS (NVARS),
        .K     (K),
        .LW    (LW)
    ) u_eval (
        .lits  (clause_lits_s),
        .x     (x_r),
        .truth (clause_true_s)
    );

    // Next-state logic for the controller, counters and status flags.
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        ci_s      = ci_r;
        nsol_s    = nsol_r;
        lcnt_s    = lcnt_r;
        kcnt_s    = kcnt_r;
        ncl_s     = ncl_r;
        full_s    = full_r;
        load_ok_s = 1'b0;
        if (clr) begin
            state_s = ST_IDLE;
            x_s     = '0;
            ci_s    = '0;
            nsol_s  = '0;
            lcnt_s  = '0;
            kcnt_s  = '0;
            ncl_s   = '0;
            full_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A load request blocks run in the same cycle even when
                    // the memory is full and the literal is dropped.
                    if (load) begin
                        if (!full_r) begin
                            load_ok_s = 1'b1;
                            lcnt_s    = lcnt_r + CW'(1);
                            full_s    = (lcnt_r == CW'(NSLOTS - 1));
                            if (kcnt_r == KW'(0)) begin
                                ncl_s = ncl_r + CIW'(1);
                            end else begin
                                ncl_s = ncl_r;
                            end
                            if (kcnt_r == KW'(K - 1)) begin
                                kcnt_s = '0;
                            end else begin
                                kcnt_s = kcnt_r + KW'(1);
                            end
                        end else begin
                            load_ok_s = 1'b0;
                        end
                    end else if (run) begin
                        state_s = ST_EVAL;
                        x_s     = '0;
                        ci_s    = '0;
                        nsol_s  = '0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    if (ncl_r == CIW'(0)) begin
                        state_s = ST_FOUND;
                        nsol_s  = nsol_r + NW'(1);
                    end else if (clause_true_s) begin
                        if (ci_r == ncl_r - CIW'(1)) begin
                            state_s = ST_FOUND;
                            nsol_s  = nsol_r + NW'(1);
                        end else begin
                            ci_s = ci_r + CIW'(1);
                        end
                    end else begin
                        if (&x_r) begin
                            state_s = ST_EXHAUSTED;
                        end else begin
                            x_s  = x_r + NVARS'(1);
                            ci_s = '0;
                        end
                    end
                end
                ST_FOUND: begin
                    if (run) begin
                        state_s = ST_EVAL;
                        x_s     = '0;
                        ci_s    = '0;
                        nsol_s  = '0;
                    end else if (next) begin
                        if (&x_r) begin
                            state_s = ST_EXHAUSTED;
                        end else begin
                            state_s = ST_EVAL;
                            x_s     = x_r + NVARS'(1);
                            ci_s    = '0;
                        end
                    end else begin
                        state_s = ST_FOUND;
                    end
                end
                ST_EXHAUSTED: begin
                    if (run) begin
                        state_s = ST_EVAL;
                        x_s     = '0;
                        ci_s    = '0;
                        nsol_s  = '0;
                    end else begin
                        state_s = ST_EXHAUSTED;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        sol_s  = (state_s == ST_FOUND);
        done_s = (state_s == ST_FOUND) || (state_s == ST_EXHAUSTED);
        busy_s = (state_s == ST_EVAL);
    end

    // Controller, counter and registered output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            x_r     <= '0;
            ci_r    <= '0;
            nsol_r  <= '0;
            lcnt_r  <= '0;
            kcnt_r  <= '0;
            ncl_r   <= '0;
            full_r  <= 1'b0;
            sol_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            x_r     <= x_s;
            ci_r    <= ci_s;
            nsol_r  <= nsol_s;
            lcnt_r  <= lcnt_s;
            kcnt_r  <= kcnt_s;
            ncl_r   <= ncl_s;
            full_r  <= full_s;
            sol_r   <= sol_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
        end
    end

    // Literal memory: cleared by reset or clr, written at slot lcnt on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOTS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NSLOTS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (load_ok_s) begin
            for (int i = 0; i < NSLOTS; i++) begin
                if (lcnt_r == CW'(i)) begin
                    mem_r[i] <= data;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end else begin
            for (int i = 0; i < NSLOTS; i++) begin
                mem_r[i] <= mem_r[i];
            end
        end
    end

    assign x    = x_r;
    assign sol  = sol_r;
    assign done = done_r;
    assign busy = busy_r;
    assign full = full_r;
    assign nsol = nsol_r;

endmodule

// File: tb/tb_tinysat_param.sv
// Testbench for tinysat_param with default parameters (6 vars, 8x3 literals).
// Expected results come from hand-computed table rows and from a search
// model that enumerates assignments and evaluates clauses directly.
module tb_tinysat_param;

    localparam int NVARS  = 6;
    localparam int K      = 3;
    localparam int LW     = 4;
    localparam int NSLOTS = 24;
    localparam int XMAX   = 63;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic             clr = 1'b0;
    logic             run = 1'b0;
    logic             next = 1'b0;
    logic [LW-1:0]    data = '0;
    logic [NVARS-1:0] x;
    logic             sol, done, busy, full;
    logic [NVARS:0]   nsol;

    tinysat_param #(.NVARS(6), .NCLAUSES(8), .K(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .clr   (clr),
        .run   (run),
        .next  (next),
        .data  (data),
        .x     (x),
        .sol   (sol),
        .done  (done),
        .busy  (busy),
        .full  (full),
        .nsol  (nsol)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int mlits[$];

    typedef struct {
        string name;
        int    nlits;
        int    lits[6];
        int    exp_x;
        int    exp_sol;
        int    exp_nsol;
        int    exp_cyc;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input string nm, input int n,
                                input int l0, input int l1, input int l2,
                                input int l3, input int l4, input int l5,
                                input int ex, input int es, input int en, input int ec);
        vec_t v;
        v.name = nm; v.nlits = n;
        v.lits[0] = l0; v.lits[1] = l1; v.lits[2] = l2;
        v.lits[3] = l3; v.lits[4] = l4; v.lits[5] = l5;
        v.exp_x = ex; v.exp_sol = es; v.exp_nsol = en; v.exp_cyc = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit lit_ok(input int v, input int xv);
        if (v == 0) return 1'b0;
        else if (v > 0) return ((xv >> (v - 1)) & 1) != 0;
        else return ((xv >> (-v - 1)) & 1) == 0;
    endfunction

    function automatic int slot(input int i);
        return (i < mlits.size()) ? mlits[i] : 0;
    endfunction

    // Try assignments from start upward; cyc counts one cycle per clause test.
    task automatic search(input int start, output bit found, output int xr, output int cyc);
        int nc;
        bit all_ok;
        bit any;
        nc = (mlits.size() + K - 1) / K;
        cyc = 0; found = 1'b0; xr = XMAX;
        for (int xv = start; xv <= XMAX; xv++) begin
            if (nc == 0) begin
                cyc++; found = 1'b1; xr = xv;
                return;
            end
            all_ok = 1'b1;
            for (int c = 0; c < nc; c++) begin
                any = 1'b0;
                cyc++;
                for (int j = 0; j < K; j++) begin
                    if (lit_ok(slot(c * K + j), xv)) any = 1'b1;
                end
                if (!any) begin
                    all_ok = 1'b0;
                    break;
                end
            end
            if (all_ok) begin
                found = 1'b1; xr = xv;
                return;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_mem();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        mlits.delete();
    endtask

    task automatic load_one(input int v);
        @(negedge clk); load = 1'b1; data = 4'(v);
        @(negedge clk); load = 1'b0;
        if (mlits.size() < NSLOTS) mlits.push_back(v);
    endtask

    // mode 0: run, 1: next, 2: run+next, 3: run then a run+next pulse mid-search.
    // cyc counts cycles spent in EVAL until done.
    task automatic go(input int mode, output int cyc);
        bit tmo;
        @(negedge clk);
        run  = (mode != 1);
        next = (mode == 1) || (mode == 2);
        @(negedge clk);
        run = 1'b0; next = 1'b0;
        cyc = 0; tmo = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                tmo = 1'b0;
                break;
            end
            if (busy) cyc++;
            if (mode == 3 && i == 10) begin
                run = 1'b1; next = 1'b1;
            end else begin
                run = 1'b0; next = 1'b0;
            end
            @(negedge clk);
        end
        run = 1'b0; next = 1'b0;
        chk("search_timeout", int'(tmo), 0);
    endtask

    initial begin
        int  cyc, mc, xr, expn, n, bad, nsols;
        bit  f;

        vecs[0] = mk("two_clause_sat",   6, 1, 2, 0, -1, 0, 0,  2, 1, 1, 5);
        vecs[1] = mk("contradiction",    6, 1, 0, 0, -1, 0, 0, 63, 0, 0, 96);
        vecs[2] = mk("no_clauses",       0, 0, 0, 0,  0, 0, 0,  0, 1, 1, 1);
        vecs[3] = mk("partial_clause",   1, 3, 0, 0,  0, 0, 0,  4, 1, 1, 5);
        vecs[4] = mk("neg_top_var",      1,-6, 0, 0,  0, 0, 0,  0, 1, 1, 1);
        vecs[5] = mk("all_zero_clause",  3, 0, 0, 0,  0, 0, 0, 63, 0, 0, 64);
        vecs[6] = mk("two_lit_partial",  5, 1, 2, 3, -1,-2, 0,  1, 1, 1, 3);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({x, sol, done, busy, full, nsol}), 0);
        rst_n = 1'b1;

        // Table-driven directed searches
        foreach (vecs[i]) begin
            clear_mem();
            for (int j = 0; j < vecs[i].nlits; j++) load_one(vecs[i].lits[j]);
            go(0, cyc);
            chk({vecs[i].name, "_x"},    int'(x),    vecs[i].exp_x);
            chk({vecs[i].name, "_sol"},  int'(sol),  vecs[i].exp_sol);
            chk({vecs[i].name, "_done"}, int'(done), 1);
            chk({vecs[i].name, "_nsol"}, int'(nsol), vecs[i].exp_nsol);
            chk({vecs[i].name, "_cyc"},  cyc,        vecs[i].exp_cyc);
        end

        // Enumerate every solution with next, then exhaust
        clear_mem();
        load_one(1); load_one(2); load_one(0); load_one(-1); load_one(0); load_one(0);
        go(0, cyc);
        nsols = int'(sol); bad = 0;
        for (int i = 0; i < 20 && sol; i++) begin
            go(1, cyc);
            if (sol) begin
                nsols++;
                if (x[1:0] != 2'b10) bad++;
            end
        end
        chk("enum_count", nsols, 16);
        chk("enum_pattern_bad", bad, 0);
        chk("enum_end_sol", int'(sol), 0);
        chk("enum_end_done", int'(done), 1);
        chk("enum_end_nsol", int'(nsol), 16);
        chk("enum_end_x", int'(x), 63);

        // run restarts from EXHAUSTED, and wins over next in FOUND
        go(0, cyc);
        chk("restart_exh_x", int'(x), 2);
        chk("restart_exh_nsol", int'(nsol), 1);
        go(2, cyc);
        chk("run_over_next_x", int'(x), 2);
        chk("run_over_next_nsol", int'(nsol), 1);
        chk("run_over_next_cyc", cyc, 5);

        // run and next ignored during EVAL
        clear_mem();
        load_one(1); load_one(0); load_one(0); load_one(-1); load_one(0); load_one(0);
        go(3, cyc);
        chk("eval_ignore_cyc", cyc, 96);
        chk("eval_ignore_x", int'(x), 63);
        chk("eval_ignore_nsol", int'(nsol), 0);

        // load outside IDLE is ignored
        clear_mem();
        for (int i = 0; i < 23; i++) load_one(1);
        chk("pre_full_23", int'(full), 0);
        go(0, cyc);
        chk("ones23_x", int'(x), 1);
        chk("ones23_cyc", cyc, 9);
        @(negedge clk); load = 1'b1; data = 4'(1);
        @(negedge clk); load = 1'b0;
        chk("load_in_found_full", int'(full), 0);
        chk("load_in_found_sol", int'(sol), 1);

        // Memory fills after 24 literals; load+run in IDLE stays idle
        clear_mem();
        for (int i = 0; i < 24; i++) begin
            load_one(1);
            if (i == 22) chk("full_after_23", int'(full), 0);
        end
        chk("full_after_24", int'(full), 1);
        @(negedge clk); load = 1'b1; run = 1'b1; data = 4'(-1);
        @(negedge clk); load = 1'b0; run = 1'b0;
        chk("load_run_busy", int'(busy), 0);
        chk("load_run_done", int'(done), 0);
        chk("load_run_full", int'(full), 1);
        go(0, cyc);
        chk("full_mem_x", int'(x), 1);
        chk("full_mem_cyc", cyc, 9);
        chk("full_mem_nsol", int'(nsol), 1);

        // Asynchronous reset mid-EVAL
        clear_mem();
        load_one(1); load_one(0); load_one(0); load_one(-1); load_one(0); load_one(0);
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", int'({x, sol, done, busy, full, nsol}), 0);
        rst_n = 1'b1;
        mlits.delete();
        go(0, cyc);
        chk("post_reset_x", int'(x), 0);
        chk("post_reset_sol", int'(sol), 1);
        chk("post_reset_nsol", int'(nsol), 1);
        chk("post_reset_cyc", cyc, 1);

        // Randomized clause sets against the search model
        for (int it = 0; it < 20; it++) begin
            clear_mem();
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : int'($urandom_range(0, 9));
            for (int i = 0; i < n; i++) load_one(int'($urandom_range(0, 12)) - 6);
            go(0, cyc);
            search(0, f, xr, mc);
            expn = int'(f);
            chk("rand_sol", int'(sol), int'(f));
            chk("rand_x", int'(x), xr);
            chk("rand_nsol", int'(nsol), expn);
            chk("rand_cyc", cyc, mc);
            for (int s = 0; s < 2; s++) begin
                if (!f) break;
                if (xr == XMAX) begin
                    f = 1'b0; mc = 0;
                end else begin
                    search(xr + 1, f, xr, mc);
                end
                expn += int'(f);
                go(1, cyc);
                chk("rand_next_sol", int'(sol), int'(f));
                chk("rand_next_x", int'(x), xr);
                chk("rand_next_nsol", int'(nsol), expn);
                chk("rand_next_cyc", cyc, mc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
